// File: rtl/dsp_pkg.sv
// Shared DSP definitions: default sample/accumulator widths and
// signed saturation limits for an arbitrary width.
package dsp_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ACC_W_DEF  = 12;

  // Largest signed value representable in w bits.
  function automatic logic signed [63:0] sat_max(input int unsigned w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest signed value representable in w bits.
  function automatic logic signed [63:0] sat_min(input int unsigned w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/complex_accum_if.sv
// Sample input and frame-result output handshakes of the complex accumulator.
interface complex_accum_if
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] re_in;
  logic [DATA_W-1:0] im_in;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  re_out;
  logic [ACC_W-1:0]  im_out;
  logic              ovf_out;

  modport master (
    output in_valid, re_in, im_in, out_ready,
    input  in_ready, out_valid, re_out, im_out, ovf_out
  );

  modport slave (
    input  in_valid, re_in, im_in, out_ready,
    output in_ready, out_valid, re_out, im_out, ovf_out
  );

endinterface

// File: rtl/complex_accum_sat_add.sv
// Signed W + W -> W adder that clamps to the representable range and
// flags when it had to clamp.
module sat_add
  import dsp_pkg::*;
#(
  parameter int unsigned W = ACC_W_DEF
) (
  input  logic signed [W-1:0] i_a,
  input  logic signed [W-1:0] i_b,
  output logic signed [W-1:0] o_sum_c,
  output logic                o_ovf_c
);

  localparam logic signed [W-1:0] MAX_V = W'(sat_max(W));
  localparam logic signed [W-1:0] MIN_V = W'(sat_min(W));

  logic signed [W:0] w_sum;

  assign w_sum = (W+1)'(i_a) + (W+1)'(i_b);

  // One guard bit: disagreement with the result MSB means the true sum left range.
  always_comb begin
    o_ovf_c = w_sum[W] ^ w_sum[W-1];
    o_sum_c = w_sum[W-1:0];
    if (o_ovf_c) begin
      o_sum_c = w_sum[W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/complex_accum.sv
// Frame accumulator for complex products: sums LEN accepted samples with
// saturation and hands each frame result out through a one-entry register.
module complex_accum
  import dsp_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF,
  parameter int unsigned LEN    = 16,
  parameter int unsigned CNT_W  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  complex_accum_if.slave  bus
);

  logic signed [ACC_W-1:0] r_acc_re;
  logic signed [ACC_W-1:0] r_acc_im;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_ovf;
  logic                    r_out_valid;
  logic signed [ACC_W-1:0] r_re_out;
  logic signed [ACC_W-1:0] r_im_out;
  logic                    r_ovf_out;

  logic signed [ACC_W-1:0] w_re_ext;
  logic signed [ACC_W-1:0] w_im_ext;
  logic signed [ACC_W-1:0] w_sum_re;
  logic signed [ACC_W-1:0] w_sum_im;
  logic                    w_ovf_re;
  logic                    w_ovf_im;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_last;

  assign w_re_ext = ACC_W'($signed(bus.re_in));
  assign w_im_ext = ACC_W'($signed(bus.im_in));

  sat_add #(.W(ACC_W)) u_add_re (
    .i_a     (r_acc_re),
    .i_b     (w_re_ext),
    .o_sum_c (w_sum_re),
    .o_ovf_c (w_ovf_re)
  );

  sat_add #(.W(ACC_W)) u_add_im (
    .i_a     (r_acc_im),
    .i_b     (w_im_ext),
    .o_sum_c (w_sum_im),
    .o_ovf_c (w_ovf_im)
  );

  // Stall only when a result is held and downstream refuses it.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready && !clear;
  assign w_last     = (r_cnt == CNT_W'(LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_re    <= '0;
      r_acc_im    <= '0;
      r_cnt       <= '0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_re_out    <= '0;
      r_im_out    <= '0;
      r_ovf_out   <= 1'b0;
    end else begin
      if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
      // clear restarts the frame but leaves a held result alone.
      if (clear) begin
        r_acc_re <= '0;
        r_acc_im <= '0;
        r_cnt    <= '0;
        r_ovf    <= 1'b0;
      end else if (w_accept) begin
        if (w_last) begin
          r_re_out    <= w_sum_re;
          r_im_out    <= w_sum_im;
          r_ovf_out   <= r_ovf | w_ovf_re | w_ovf_im;
          r_out_valid <= 1'b1;
          r_acc_re    <= '0;
          r_acc_im    <= '0;
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
        end else begin
          r_acc_re <= w_sum_re;
          r_acc_im <= w_sum_im;
          r_cnt    <= r_cnt + CNT_W'(1);
          r_ovf    <= r_ovf | w_ovf_re | w_ovf_im;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.re_out    = r_re_out;
  assign bus.im_out    = r_im_out;
  assign bus.ovf_out   = r_ovf_out;

endmodule
